// File: rtl/modport_bridge_if.sv
// AHB-side and APB-side signal bundle for the AHB-to-APB bridge.
// The bridge uses the slave modport; an AHB master / APB slave model uses master.
interface modport_bridge_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [2:0]  Hburst;
  logic [2:0]  Hsize;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Hburst, Hsize, Prdata,
    output Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Hburst, Hsize, Prdata,
    input  Hreadyout, Hresp, Hrdata, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/modport_bridge.sv
// AHB-to-APB bridge: Moore FSM converting pipelined AHB transfers into
// two-cycle APB setup/enable accesses to three slaves at 0x8000_0000-0x8BFF_FFFF.
module modport_bridge (
  input  logic            clk,
  input  logic            Hresetn,
  modport_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE, WRITEP, WENABLEP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] haddr1_q, haddr1_d, haddr2_q, haddr2_d;
  logic        hwrite1_q, hwrite1_d, hwrite2_q, hwrite2_d;
  logic [3:0]  pselx_q, pselx_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] src_addr;
  logic        valid;
  logic        unused_attr;

  function automatic logic [3:0] decode(input logic [31:0] a);
    case (a[27:26])
      2'b00:   decode = 4'b0001;
      2'b01:   decode = 4'b0010;
      2'b10:   decode = 4'b0100;
      default: decode = 4'b0000;
    endcase
  endfunction

  assign valid = bus.Hreadyin && bus.Htrans[1] &&
                 (bus.Haddr[31:28] == 4'h8) && (bus.Haddr[27:26] != 2'b11);

  assign unused_attr = ^{bus.Hburst, bus.Hsize};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RENABLE, WENABLE: begin
        if (valid && !bus.Hwrite) state_d = READ;
        else if (valid)           state_d = WWAIT;
        else                      state_d = IDLE;
      end
      READ:     state_d = RENABLE;
      WWAIT:    state_d = valid ? WRITEP : WRITE;
      WRITE:    state_d = WENABLE;
      WRITEP:   state_d = WENABLEP;
      WENABLEP: begin
        if (!hwrite2_q)  state_d = READ;
        else if (valid)  state_d = WRITEP;
        else             state_d = WRITE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // WWAIT holds the address latched one edge ago; WENABLEP serves the transfer
  // accepted two edges ago (the one stalled behind the previous write).
  always_comb begin
    if (state_q == WWAIT)         src_addr = haddr1_q;
    else if (state_q == WENABLEP) src_addr = haddr2_q;
    else                          src_addr = bus.Haddr;
  end

  always_comb begin
    haddr1_d  = bus.Haddr;
    haddr2_d  = haddr1_q;
    hwrite1_d = bus.Hwrite;
    hwrite2_d = hwrite1_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (state_d)
      READ: begin
        pselx_d   = decode(src_addr);
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = src_addr;
      end
      WRITE, WRITEP: begin
        pselx_d   = decode(src_addr);
        penable_d = 1'b0;
        pwrite_d  = 1'b1;
        paddr_d   = src_addr;
        pwdata_d  = bus.Hwdata;
      end
      RENABLE, WENABLE, WENABLEP: penable_d = 1'b1;
      default: begin
        pselx_d   = 4'b0000;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Hresetn) begin
    if (Hresetn) begin
      state_q   <= IDLE;
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwrite1_q <= 1'b0;
      hwrite2_q <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      haddr1_q  <= haddr1_d;
      haddr2_q  <= haddr2_d;
      hwrite1_q <= hwrite1_d;
      hwrite2_q <= hwrite2_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign bus.Hreadyout = !(state_q inside {READ, WRITE, WRITEP});
  assign bus.Hresp     = 2'b00;
  assign bus.Hrdata    = bus.Prdata;
  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: single/back-to-back transfers, address
// range edges, ignored transfers and asynchronous reset during an access.
module tb_modport_bridge;
  logic clk;
  logic Hresetn;
  logic hrdy_en;
  int   n_checks;
  int   n_fail;

  modport_bridge_if bus ();

  modport_bridge dut (
    .clk     (clk),
    .Hresetn (Hresetn),
    .bus     (bus.slave)
  );

  // Single-slave AHB system: the master sees the bridge's own ready.
  assign bus.Hreadyin = bus.Hreadyout & hrdy_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.Htrans = 2'b00;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h0;
    bus.Hwdata = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] t);
    bus.Haddr  = a;
    bus.Hwrite = w;
    bus.Htrans = t;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    hrdy_en    = 1'b1;
    Hresetn    = 1'b1;
    bus.Hburst = 3'b000;
    bus.Hsize  = 3'b010;
    bus.Prdata = 32'h0;
    idle_bus();
    #2;
    chk("rst_pselx",   32'(bus.Pselx), 32'h0);
    chk("rst_penable", 32'(bus.Penable), 32'h0);
    chk("rst_pwrite",  32'(bus.Pwrite), 32'h0);
    chk("rst_paddr",   bus.Paddr, 32'h0);
    chk("rst_pwdata",  bus.Pwdata, 32'h0);
    chk("rst_hready",  32'(bus.Hreadyout), 32'h1);
    chk("rst_hresp",   32'(bus.Hresp), 32'h0);
    tick();
    tick();
    Hresetn = 1'b0;
    tick();

    // single write
    addr_phase(32'h8000_0010, 1'b1, 2'b10);
    tick();
    chk("wr_c1_pselx",  32'(bus.Pselx), 32'h0);
    chk("wr_c1_hready", 32'(bus.Hreadyout), 32'h1);
    idle_bus();
    bus.Hwdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_c2_pselx",   32'(bus.Pselx), 32'h1);
    chk("wr_c2_pwrite",  32'(bus.Pwrite), 32'h1);
    chk("wr_c2_penable", 32'(bus.Penable), 32'h0);
    chk("wr_c2_paddr",   bus.Paddr, 32'h8000_0010);
    chk("wr_c2_pwdata",  bus.Pwdata, 32'hDEAD_BEEF);
    chk("wr_c2_hready",  32'(bus.Hreadyout), 32'h0);
    bus.Hwdata = 32'h0;
    tick();
    chk("wr_c3_penable", 32'(bus.Penable), 32'h1);
    chk("wr_c3_pselx",   32'(bus.Pselx), 32'h1);
    chk("wr_c3_pwdata",  bus.Pwdata, 32'hDEAD_BEEF);
    chk("wr_c3_hready",  32'(bus.Hreadyout), 32'h1);
    tick();
    chk("wr_c4_pselx",   32'(bus.Pselx), 32'h0);
    chk("wr_c4_penable", 32'(bus.Penable), 32'h0);

    // single read
    addr_phase(32'h8400_0004, 1'b0, 2'b10);
    bus.Prdata = 32'h1234_5678;
    tick();
    chk("rd_c1_pselx",   32'(bus.Pselx), 32'h2);
    chk("rd_c1_hready",  32'(bus.Hreadyout), 32'h0);
    chk("rd_c1_penable", 32'(bus.Penable), 32'h0);
    chk("rd_c1_paddr",   bus.Paddr, 32'h8400_0004);
    chk("rd_c1_pwrite",  32'(bus.Pwrite), 32'h0);
    idle_bus();
    tick();
    chk("rd_c2_penable", 32'(bus.Penable), 32'h1);
    chk("rd_c2_hrdata",  bus.Hrdata, 32'h1234_5678);
    chk("rd_c2_hready",  32'(bus.Hreadyout), 32'h1);
    chk("rd_c2_pselx",   32'(bus.Pselx), 32'h2);
    tick();
    chk("rd_c3_pselx",   32'(bus.Pselx), 32'h0);
    bus.Prdata = 32'hCAFE_F00D;
    #1;
    chk("hrdata_comb",   bus.Hrdata, 32'hCAFE_F00D);

    // back-to-back writes
    addr_phase(32'h8800_0000, 1'b1, 2'b10);
    tick();
    addr_phase(32'h8800_0004, 1'b1, 2'b11);
    bus.Hwdata = 32'h1111_1111;
    tick();
    chk("b2b_wp_pselx",   32'(bus.Pselx), 32'h4);
    chk("b2b_wp_paddr",   bus.Paddr, 32'h8800_0000);
    chk("b2b_wp_pwdata",  bus.Pwdata, 32'h1111_1111);
    chk("b2b_wp_pwrite",  32'(bus.Pwrite), 32'h1);
    chk("b2b_wp_penable", 32'(bus.Penable), 32'h0);
    chk("b2b_wp_hready",  32'(bus.Hreadyout), 32'h0);
    idle_bus();
    bus.Hwdata = 32'h2222_2222;
    tick();
    chk("b2b_wep_penable", 32'(bus.Penable), 32'h1);
    chk("b2b_wep_hready",  32'(bus.Hreadyout), 32'h1);
    chk("b2b_wep_paddr",   bus.Paddr, 32'h8800_0000);
    tick();
    chk("b2b_w_paddr",   bus.Paddr, 32'h8800_0004);
    chk("b2b_w_pwdata",  bus.Pwdata, 32'h2222_2222);
    chk("b2b_w_penable", 32'(bus.Penable), 32'h0);
    chk("b2b_w_pselx",   32'(bus.Pselx), 32'h4);
    chk("b2b_w_hready",  32'(bus.Hreadyout), 32'h0);
    bus.Hwdata = 32'h0;
    tick();
    chk("b2b_we_penable", 32'(bus.Penable), 32'h1);
    chk("b2b_we_paddr",   bus.Paddr, 32'h8800_0004);
    tick();
    chk("b2b_end_pselx",  32'(bus.Pselx), 32'h0);

    // ignored transfers
    addr_phase(32'h9000_0000, 1'b1, 2'b10);
    tick();
    chk("oor_c1_pselx",  32'(bus.Pselx), 32'h0);
    chk("oor_c1_hready", 32'(bus.Hreadyout), 32'h1);
    idle_bus();
    tick();
    chk("oor_c2_pselx",  32'(bus.Pselx), 32'h0);
    addr_phase(32'h8000_0000, 1'b0, 2'b00);
    tick();
    chk("htrans_idle_pselx",  32'(bus.Pselx), 32'h0);
    chk("htrans_idle_hready", 32'(bus.Hreadyout), 32'h1);
    addr_phase(32'h8000_0000, 1'b0, 2'b01);
    tick();
    chk("htrans_busy_pselx", 32'(bus.Pselx), 32'h0);
    addr_phase(32'h8C00_0000, 1'b0, 2'b10);
    tick();
    chk("oor_8c_pselx", 32'(bus.Pselx), 32'h0);
    addr_phase(32'h7FFF_FFFC, 1'b0, 2'b10);
    tick();
    chk("oor_7f_pselx", 32'(bus.Pselx), 32'h0);
    hrdy_en = 1'b0;
    addr_phase(32'h8000_0000, 1'b0, 2'b10);
    tick();
    chk("hreadyin_low_pselx", 32'(bus.Pselx), 32'h0);
    hrdy_en = 1'b1;
    idle_bus();
    tick();

    // top of range selects slave 2
    addr_phase(32'h8BFF_FFFC, 1'b0, 2'b10);
    tick();
    chk("top_pselx", 32'(bus.Pselx), 32'h4);
    chk("top_paddr", bus.Paddr, 32'h8BFF_FFFC);
    idle_bus();
    tick();
    tick();
    addr_phase(32'h87FF_FFFC, 1'b0, 2'b10);
    tick();
    chk("s1_top_pselx", 32'(bus.Pselx), 32'h2);
    idle_bus();
    tick();
    tick();

    // write followed by read
    addr_phase(32'h8000_0020, 1'b1, 2'b10);
    tick();
    addr_phase(32'h8400_0040, 1'b0, 2'b10);
    bus.Hwdata = 32'hAAAA_5555;
    tick();
    chk("wr_rd_wp_paddr",  bus.Paddr, 32'h8000_0020);
    chk("wr_rd_wp_pwdata", bus.Pwdata, 32'hAAAA_5555);
    chk("wr_rd_wp_pselx",  32'(bus.Pselx), 32'h1);
    chk("wr_rd_wp_pwrite", 32'(bus.Pwrite), 32'h1);
    idle_bus();
    tick();
    chk("wr_rd_wep_penable", 32'(bus.Penable), 32'h1);
    tick();
    chk("wr_rd_r_paddr",   bus.Paddr, 32'h8400_0040);
    chk("wr_rd_r_pwrite",  32'(bus.Pwrite), 32'h0);
    chk("wr_rd_r_pselx",   32'(bus.Pselx), 32'h2);
    chk("wr_rd_r_penable", 32'(bus.Penable), 32'h0);
    chk("wr_rd_r_hready",  32'(bus.Hreadyout), 32'h0);
    bus.Prdata = 32'h55AA_55AA;
    tick();
    chk("wr_rd_re_penable", 32'(bus.Penable), 32'h1);
    chk("wr_rd_re_hrdata",  bus.Hrdata, 32'h55AA_55AA);
    tick();
    chk("wr_rd_end_pselx", 32'(bus.Pselx), 32'h0);

    // reset pulse during RENABLE
    addr_phase(32'h8800_0010, 1'b0, 2'b10);
    tick();
    idle_bus();
    tick();
    chk("rst_mid_penable_before", 32'(bus.Penable), 32'h1);
    #2;
    Hresetn = 1'b1;
    #1;
    chk("rst_mid_pselx",   32'(bus.Pselx), 32'h0);
    chk("rst_mid_penable", 32'(bus.Penable), 32'h0);
    chk("rst_mid_paddr",   bus.Paddr, 32'h0);
    chk("rst_mid_pwdata",  bus.Pwdata, 32'h0);
    chk("rst_mid_pwrite",  32'(bus.Pwrite), 32'h0);
    chk("rst_mid_hready",  32'(bus.Hreadyout), 32'h1);
    tick();
    Hresetn = 1'b0;
    tick();
    chk("post_rst_pselx",  32'(bus.Pselx), 32'h0);
    chk("post_rst_hready", 32'(bus.Hreadyout), 32'h1);
    chk("post_rst_hresp",  32'(bus.Hresp), 32'h0);
    addr_phase(32'h8000_0008, 1'b0, 2'b10);
    tick();
    chk("post_rst_rd_pselx", 32'(bus.Pselx), 32'h1);
    chk("post_rst_rd_paddr", bus.Paddr, 32'h8000_0008);
    idle_bus();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
